fetch_unit: RTL

Instruction fetch stage directly upstream of the main decoder/control unit. Holds the PC and issues requests to instruction memory over a req/ready handshake. Latches the returned word into an instruction register and presents opcode[5:0] and funct[3:0] to control. Computes the next PC (sequential, branch or jump) once the datapath signals that the current instruction has completed.

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_next_pc.sv | 35 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants seen
// by control, the fetch state encoding and the branch offset helper.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b101111;
  localparam logic [5:0] OP_LW    = 6'b110000;
  localparam logic [5:0] OP_SW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110010;
  localparam logic [5:0] OP_BLT   = 6'b110011;
  localparam logic [5:0] OP_SUBI  = 6'b110100;
  localparam logic [5:0] OP_ADDI  = 6'b110101;
  localparam logic [5:0] OP_BEQI  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b110111;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Word-aligned byte offset of a 16-bit signed branch immediate.
  function automatic logic [31:0] sext_imm_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection for the fetch stage: jump target, taken branch target
// or the sequential address. Purely combinational.
module next_pc_logic
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_field,
  input  logic [5:0]  opcode,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic [31:0] next_pc
);

  logic        branch_cond;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] raw_pc;

  // Pick the flag that decides the branch, then the target with jump first.
  always_comb begin
    branch_cond   = (opcode == OP_BLT) ? alu_lt : alu_zero;
    branch_target = pc_plus4 + sext_imm_x4(instr_field[15:0]);
    jump_target   = {pc_plus4[31:28], instr_field, 2'b00};
    raw_pc        = pc_plus4;
    if (jump) begin
      raw_pc = jump_target;
    end else if (branch && branch_cond) begin
      raw_pc = branch_target;
    end
    next_pc = {raw_pc[31:2], 2'b00};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over the imem handshake,
// keeps the instruction register for control and advances the PC once the
// datapath reports the current instruction done.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [3:0]          funct,
  output logic                instr_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  input  logic                ex_done,
  input  logic                branch,
  input  logic                jump,
  input  logic                alu_zero,
  input  logic                alu_lt,
  output logic                halted,
  output logic                fetch_err,
  output logic [31:0]         retired
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [8:0]  TIMEOUT_LIMIT    = 9'(FETCH_TIMEOUT);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  retired_q, retired_d;
  logic         err_q, err_d;
  logic [7:0]   tmo_cnt_q, tmo_cnt_d;
  logic [31:0]  next_pc;

  next_pc_logic u_next_pc (
    .pc_plus4    (pc_plus4),
    .instr_field (instr_q[25:0]),
    .opcode      (instr_q[31:26]),
    .branch      (branch),
    .jump        (jump),
    .alu_zero    (alu_zero),
    .alu_lt      (alu_lt),
    .next_pc     (next_pc)
  );

  // State, PC, instruction register and counters; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
      err_q     <= 1'b0;
      tmo_cnt_q <= 8'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Fetch/execute sequencing: latch on ready, time out a silent memory, retire on ex_done.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ready) begin
          instr_d   = imem.imem_rdata;
          tmo_cnt_d = 8'h0;
          state_d   = ST_EXEC;
        end else if (({1'b0, tmo_cnt_q} + 9'd1) >= TIMEOUT_LIMIT) begin
          err_d     = 1'b1;
          tmo_cnt_d = 8'h0;
          state_d   = ST_HALT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          retired_d = retired_q + 32'd1;
          if (instr_q[31:26] == OP_HALT) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded straight from the registers so reset drops them asynchronously.
  always_comb begin
    imem.imem_req  = (state_q == ST_FETCH);
    imem.imem_addr = pc_q;
    instr          = instr_q;
    opcode         = instr_q[31:26];
    funct          = instr_q[3:0];
    instr_valid    = (state_q == ST_EXEC);
    pc             = pc_q;
    pc_plus4       = pc_q + 32'd4;
    halted         = (state_q == ST_HALT);
    fetch_err      = err_q;
    retired        = retired_q;
  end

endmodule
